// File: rtl/shift_engine_pkg.sv
// Shared definitions for the multi-cycle shift engine: mode encodings, FSM state type and
// the shift-amount width derivation.
package shift_engine_pkg;

  localparam logic [2:0] ModeSrl = 3'b000;
  localparam logic [2:0] ModeSll = 3'b001;
  localparam logic [2:0] ModeSra = 3'b010;
  localparam logic [2:0] ModeRor = 3'b011;
  localparam logic [2:0] ModeRol = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // At least one bit so a WIDTH of 2 still gets a usable shift-amount port.
  function automatic int unsigned shamt_w(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic is_valid_mode(input logic [2:0] mode);
    return mode <= ModeRol;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step with carry-out of the bit that leaves the word.
module shift_step
  import shift_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  always_comb begin
    data_o  = data_i;
    carry_o = 1'b0;
    case (mode_i)
      ModeSrl: begin
        data_o  = {1'b0, data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      ModeSll: begin
        data_o  = {data_i[WIDTH-2:0], 1'b0};
        carry_o = data_i[WIDTH-1];
      end
      ModeSra: begin
        data_o  = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      ModeRor: begin
        data_o  = {data_i[0], data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      ModeRol: begin
        data_o  = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        carry_o = data_i[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// Iterative shifter: captures an operand, applies one 1-bit step per cycle for N cycles and
// publishes {carry, result} with a one-cycle completion pulse.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = shamt_w(WIDTH)
) (
  input  logic               CLK_shift,
  input  logic               RST_shift,
  input  logic [WIDTH-1:0]   A_shift,
  input  logic [WIDTH-1:0]   B_shift,
  input  logic               OP_SEL_shift,
  input  logic [2:0]         ALU_FUN_shift,
  input  logic [SHAMT_W-1:0] SHAMT_shift,
  input  logic               Shift_Enable,
  output logic               SHIFT_Busy,
  output logic [WIDTH:0]     SHIFT_OUT,
  output logic               SHIFT_Flag
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               carry_q, carry_d;
  logic [2:0]         mode_q, mode_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]     out_q, out_d;
  logic               flag_q, flag_d;

  logic [WIDTH-1:0]   step_data;
  logic               step_carry;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_shift_step (
    .data_i (work_q),
    .mode_i (mode_q),
    .data_o (step_data),
    .carry_o(step_carry)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flag_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Shift_Enable) begin
          work_d  = OP_SEL_shift ? B_shift : A_shift;
          mode_d  = ALU_FUN_shift;
          carry_d = 1'b0;
          // Reserved modes degrade to a zero-length passthrough.
          cnt_d   = is_valid_mode(ALU_FUN_shift) ? SHAMT_shift : '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          work_d  = step_data;
          carry_d = step_carry;
          cnt_d   = cnt_q - SHAMT_W'(1);
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_d   = {carry_q, work_q};
        flag_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_shift) begin
    if (RST_shift) begin
      state_q <= StIdle;
      work_q  <= '0;
      carry_q <= 1'b0;
      mode_q  <= ModeSrl;
      cnt_q   <= '0;
      out_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
    end
  end

  assign SHIFT_Busy = (state_q != StIdle);
  assign SHIFT_OUT  = out_q;
  assign SHIFT_Flag = flag_q;

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine (WIDTH=16): directed cases plus randomized operations
// checked against an arithmetic shift/rotate model, including latency and hold behaviour.
module tb_shift_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        sel = 1'b0;
  logic [2:0]  fun = '0;
  logic [3:0]  shamt = '0;
  logic        en = 1'b0;
  logic        busy;
  logic [16:0] out;
  logic        flag;

  int unsigned nvec = 0, nfail = 0, cyc = 0;
  logic [16:0] last_out = '0;

  typedef struct {
    logic [16:0] val;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  shift_engine #(
    .WIDTH(16)
  ) dut (
    .CLK_shift    (clk),
    .RST_shift    (rst),
    .A_shift      (a),
    .B_shift      (b),
    .OP_SEL_shift (sel),
    .ALU_FUN_shift(fun),
    .SHAMT_shift  (shamt),
    .Shift_Enable (en),
    .SHIFT_Busy   (busy),
    .SHIFT_OUT    (out),
    .SHIFT_Flag   (flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Whole-amount reference: result and the last bit to leave the word.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [2:0] m, input int n);
    logic [15:0] r;
    logic        c;
    if (m > 3'd4 || n == 0) return {1'b0, x};
    case (m)
      3'd0:    begin r = x >> n;                    c = x[n-1];  end
      3'd1:    begin r = x << n;                    c = x[16-n]; end
      3'd2:    begin r = $signed(x) >>> n;          c = x[n-1];  end
      3'd3:    begin r = (x >> n) | (x << (16-n));  c = x[n-1];  end
      default: begin r = (x << n) | (x >> (16-n));  c = x[16-n]; end
    endcase
    return {c, r};
  endfunction

  // Monitor: samples just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (flag) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL spurious_flag act=%h req=no_pulse", out);
      end else begin
        e = sb.pop_front();
        check("result", 32'(out), 32'(e.val));
        check("latency", cyc, e.cyc);
        check("busy_at_flag", 32'(busy), 32'd0);
        last_out = e.val;
      end
    end else begin
      check("out_hold", 32'(out), 32'(last_out));
    end
  end

  task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic s,
                       input logic [2:0] m, input int n, input int poke_at);
    int   neff;
    logic busy_ok;
    bit   seen;
    neff = (m > 3'd4) ? 0 : n;
    a = ai; b = bi; sel = s; fun = m; shamt = 4'(n); en = 1'b1;
    sb.push_back('{model(s ? bi : ai, m, n), cyc + 1 + neff + 2});
    @(negedge clk);
    busy_ok = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      en = 1'b0;
      if (flag) begin
        seen = 1'b1;
      end else begin
        busy_ok &= busy;
        a = 16'($urandom); b = 16'($urandom); sel = 1'($urandom);
        fun = 3'($urandom); shamt = 4'($urandom);
        if (i == poke_at) en = 1'b1;
        @(negedge clk);
      end
    end
    check("busy_during_op", 32'(busy_ok), 32'd1);
    check("flag_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_out", 32'(out), 32'd0);
    check("reset_flag", 32'(flag), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h8001, 16'h0000, 1'b0, 3'd0, 1, -1);
    do_op(16'h0000, 16'h8000, 1'b1, 3'd2, 15, -1);
    do_op(16'h1234, 16'h0000, 1'b0, 3'd4, 4, -1);
    do_op(16'h2341, 16'h0000, 1'b0, 3'd3, 4, -1);
    do_op(16'h1234, 16'h0000, 1'b0, 3'd1, 0, -1);
    do_op(16'h00FF, 16'h0000, 1'b0, 3'd1, 8, 3);
    do_op(16'hBEEF, 16'h0000, 1'b0, 3'd7, 5, -1);

    // Abort mid-operation; enable is also high during reset.
    a = 16'hFFFF; sel = 1'b0; fun = 3'd0; shamt = 4'd10; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; en = 1'b1; last_out = '0;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    check("abort_out", 32'(out), 32'd0);
    check("abort_flag", 32'(flag), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (15) @(negedge clk);
    do_op(16'h0F0F, 16'h0000, 1'b0, 3'd0, 3, -1);

    for (int k = 0; k < 50; k++) begin
      int n;
      n = int'($urandom_range(0, 15));
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), n,
            int'($urandom_range(0, 20)) - 2);
    end

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
